// File: rtl/crc32_mpeg2_checker.sv
// Bit-serial CRC-32/MPEG-2 receive checker: payload then 32-bit trailer, both MSB-first.
// Optional failed-frame counter enabled by defining CRC_ERR_COUNT_EN.
module crc32_mpeg2_checker #(
  parameter int unsigned PAYLOAD_BITS = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        data_valid_in,
  input  logic        data_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        crc_ok_out,
  output logic [31:0] crc_calc_out,
  output logic [31:0] crc_rx_out,
  output logic [15:0] err_count_out
);

  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
  localparam logic [15:0] LAST_PAY = 16'(PAYLOAD_BITS - 1);
  localparam logic [15:0] LAST_TRL = 16'd31;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TRAILER} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] rx_q, rx_d;
  logic        ok_q, ok_d;
  logic        done_q, done_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= '1;
      rx_q    <= '0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
    end
  end

  // start_in has priority in every state, so a start while busy restarts cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    rx_d    = rx_q;
    ok_d    = ok_q;
    done_d  = 1'b0;
    if (start_in) begin
      state_d = S_PAYLOAD;
      cnt_d   = '0;
      crc_d   = '1;
      rx_d    = '0;
      ok_d    = 1'b0;
    end else begin
      case (state_q)
        S_PAYLOAD: if (data_valid_in) begin
          crc_d = {crc_q[30:0], 1'b0} ^ ((data_in ^ crc_q[31]) ? POLY : 32'h0);
          if (cnt_q == LAST_PAY) begin
            state_d = S_TRAILER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_TRAILER: if (data_valid_in) begin
          rx_d = {rx_q[30:0], data_in};
          if (cnt_q == LAST_TRL) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
            ok_d    = (crc_q == {rx_q[30:0], data_in});
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_out     = (state_q != S_IDLE);
  assign done_out     = done_q;
  assign crc_ok_out   = ok_q;
  assign crc_calc_out = crc_q;
  assign crc_rx_out   = rx_q;

`ifdef CRC_ERR_COUNT_EN
  logic [15:0] err_cnt_q;

  // Counts in step with done_out so the new value shows alongside the pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_cnt_q <= '0;
    end else if (done_d && !ok_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count_out = err_cnt_q;
`else
  assign err_count_out = 16'h0000;
`endif

endmodule

// File: tb/tb_crc32_mpeg2_checker.sv
// Directed bench for crc32_mpeg2_checker with PAYLOAD_BITS=72 ("123456789" payload).
module tb_crc32_mpeg2_checker;

  localparam int PB = 72;
  localparam logic [31:0] GOOD = 32'h0376_E6E7;

  logic        clk = 1'b0;
  logic        rst_n, start, valid, din;
  logic        busy, done, ok;
  logic [31:0] calc, rx;
  logic [15:0] errc;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  int fr_cycles, fr_done, fr_nobusy;
  logic [PB-1:0] payload = 72'h31_3233_3435_3637_3839;

  typedef struct {
    string       name;
    logic [31:0] trl;
    int          gap;
    logic        exp_ok;
  } vec_t;
  vec_t vecs[5];

  crc32_mpeg2_checker #(.PAYLOAD_BITS(PB)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .data_valid_in(valid),
    .data_in(din), .busy_out(busy), .done_out(done), .crc_ok_out(ok),
    .crc_calc_out(calc), .crc_rx_out(rx), .err_count_out(errc)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cyc();
    fr_cycles++;
    if (done === 1'b1) fr_done++;
    if (busy !== 1'b1) fr_nobusy++;
  endtask

  task automatic drive_bit(logic b, int gap);
    if (gap > 0) begin
      for (int g = 0; g < $urandom_range(gap, 0); g++) begin
        valid = 1'b0;
        din   = 1'($urandom);
        tick();
      end
    end
    valid = 1'b1;
    din   = b;
    tick();
    valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    valid = 1'($urandom);
    din   = 1'($urandom);
    cyc();
    start = 1'b0;
    valid = 1'b0;
  endtask

  // Sends a full frame; leaves the bench in the done_out cycle unless tail is set.
  task automatic send_frame(string nm, logic [31:0] trl, int gap, logic exp_ok, bit tail);
    fr_cycles = 1; fr_done = 0; fr_nobusy = 0;
    do_start();
    for (int i = PB - 1; i >= 0; i--) drive_bit(payload[i], gap);
    for (int i = 31; i >= 0; i--) drive_bit(trl[i], gap);
    if (!exp_ok) exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 1;
`ifndef CRC_ERR_COUNT_EN
    exp_err = 0;
`endif
    if (gap == 0) chk({nm, " latency"}, 32'(fr_cycles), 32'd105);
    chk({nm, " done pulses"}, 32'(fr_done), 32'd1);
    chk({nm, " busy low cycles"}, 32'(fr_nobusy), 32'd1);
    chk({nm, " done"}, {31'd0, done}, 32'd1);
    chk({nm, " ok"}, {31'd0, ok}, {31'd0, exp_ok});
    chk({nm, " calc"}, calc, GOOD);
    chk({nm, " rx"}, rx, trl);
    chk({nm, " errcnt"}, {16'd0, errc}, 32'(exp_err));
    if (tail) begin
      cyc();
      chk({nm, " done falls"}, {31'd0, done}, 32'd0);
      chk({nm, " ok held"}, {31'd0, ok}, {31'd0, exp_ok});
      chk({nm, " rx held"}, rx, trl);
    end
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, " busy"}, {31'd0, busy}, 32'd0);
    chk({nm, " done"}, {31'd0, done}, 32'd0);
    chk({nm, " ok"}, {31'd0, ok}, 32'd0);
    chk({nm, " calc"}, calc, 32'hFFFF_FFFF);
    chk({nm, " rx"}, rx, 32'd0);
    chk({nm, " errcnt"}, {16'd0, errc}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"good",        GOOD,          0, 1'b1};
    vecs[1] = '{"corrupt_lsb", 32'h0376_E6E6, 0, 1'b0};
    vecs[2] = '{"stall",       GOOD,          5, 1'b1};
    vecs[3] = '{"corrupt_msb", 32'h8376_E6E7, 0, 1'b0};
    vecs[4] = '{"stall_bad",   32'h0376_E6E6, 3, 1'b0};

    rst_n = 1'b0; start = 1'b0; valid = 1'b0; din = 1'b0;
    repeat (3) cyc();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    // Valid data while idle must be ignored.
    valid = 1'b1; din = 1'b1;
    repeat (4) cyc();
    valid = 1'b0;
    chk("idle ignore calc", calc, 32'hFFFF_FFFF);
    chk("idle ignore busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 5; v++) send_frame(vecs[v].name, vecs[v].trl, vecs[v].gap, vecs[v].exp_ok, 1'b1);

    // Back-to-back: second start lands in the done cycle of the first.
    send_frame("b2b_first", 32'h0376_E6E6, 0, 1'b0, 1'b0);
    send_frame("b2b_second", GOOD, 0, 1'b1, 1'b1);

    // Restart after 40 payload bits: the aborted frame yields no done and no count.
    fr_cycles = 1; fr_done = 0; fr_nobusy = 0;
    do_start();
    for (int i = PB - 1; i > PB - 41; i--) drive_bit(~payload[i], 0);
    chk("restart pre done", 32'(fr_done), 32'd0);
    chk("restart pre busy", 32'(fr_nobusy), 32'd0);
    send_frame("restart", GOOD, 0, 1'b1, 1'b1);

    // Reset mid-frame after 50 payload bits.
    fr_cycles = 1; fr_done = 0; fr_nobusy = 0;
    do_start();
    for (int i = PB - 1; i > PB - 51; i--) drive_bit(payload[i], 0);
    rst_n = 1'b0;
    #1;
    exp_err = 0;
    chk_reset_vals("midreset");
    cyc();
    rst_n = 1'b1;
    fr_done = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (done === 1'b1) fr_done++;
    end
    chk("midreset no done", 32'(fr_done), 32'd0);
    send_frame("after_reset", GOOD, 0, 1'b1, 1'b1);

`ifdef CRC_ERR_COUNT_EN
    force dut.err_cnt_q = 16'hFFFE;
    cyc();
    release dut.err_cnt_q;
    exp_err = 16'hFFFE;
    send_frame("sat1", 32'h0376_E6E6, 0, 1'b0, 1'b1);
    send_frame("sat2", 32'h0376_E6E6, 0, 1'b0, 1'b1);
    chk("sat hold", {16'd0, errc}, 32'h0000_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
